// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between a master and the RAM responder (32-bit data, 1-bit IDs).
interface axi_ram_slave_if;
  logic        S_AXI_AWID;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;
  logic [1:0]  S_AXI_AWBURST;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic        S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic        S_AXI_ARID;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;
  logic [1:0]  S_AXI_ARBURST;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic        S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: independent write (AW/W/B) and read (AR/R) engines on a
// dual-port word RAM. One outstanding burst per direction, 1 beat/cycle.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 14
) (
  input logic CLK,
  input logic RST,
  axi_ram_slave_if.slave s_axi
);
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  wstate_t             wstate_q, wstate_d;
  logic [WORD_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                wfixed_q, wfixed_d, wid_q, wid_d, werr_q, werr_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                mem_we;

  rstate_t             rstate_q, rstate_d;
  logic [WORD_W-1:0]   raddr_q, raddr_d, ren_addr;
  logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic                rfixed_q, rfixed_d, rid_q, rid_d;
  logic                ren;
  logic [31:0]         rdata_q;

  // Write engine: next state, burst bookkeeping and RAM write enable.
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wfixed_d = wfixed_q;
    wid_d    = wid_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: if (s_axi.S_AXI_AWVALID) begin
        waddr_d  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
        wlen_d   = s_axi.S_AXI_AWLEN;
        wfixed_d = (s_axi.S_AXI_AWBURST == 2'b00);
        wid_d    = s_axi.S_AXI_AWID;
        wcnt_d   = 8'd0;
        werr_d   = 1'b0;
        wstate_d = W_DATA;
      end
      W_DATA: if (s_axi.S_AXI_WVALID) begin
        mem_we  = 1'b1;
        waddr_d = wfixed_q ? waddr_q : waddr_q + WORD_W'(1);
        wcnt_d  = wcnt_q + 8'd1;
        // WLAST must coincide with the len-th beat; the count, not WLAST, ends the burst.
        werr_d  = werr_q | (s_axi.S_AXI_WLAST != (wcnt_q == wlen_q));
        if (wcnt_q == wlen_q) begin
          bresp_d  = werr_d ? 2'b10 : 2'b00;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write engine state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wfixed_q <= 1'b0;
      wid_q    <= 1'b0;
      werr_q   <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wfixed_q <= wfixed_d;
      wid_q    <= wid_d;
      werr_q   <= werr_d;
      bresp_q  <= bresp_d;
    end
  end

  // RAM write port with byte enables; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.S_AXI_WSTRB[b]) mem[waddr_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
    end
  end

  // Read engine: the next beat is fetched in the same cycle the current one is accepted.
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rfixed_d = rfixed_q;
    rid_d    = rid_q;
    ren      = 1'b0;
    ren_addr = raddr_q;
    case (rstate_q)
      R_IDLE: if (s_axi.S_AXI_ARVALID) begin
        raddr_d  = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
        rlen_d   = s_axi.S_AXI_ARLEN;
        rfixed_d = (s_axi.S_AXI_ARBURST == 2'b00);
        rid_d    = s_axi.S_AXI_ARID;
        rcnt_d   = 8'd0;
        rstate_d = R_FETCH;
      end
      R_FETCH: begin
        ren      = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: if (s_axi.S_AXI_RREADY) begin
        if (rcnt_q == rlen_q) begin
          rstate_d = R_IDLE;
        end else begin
          raddr_d  = rfixed_q ? raddr_q : raddr_q + WORD_W'(1);
          rcnt_d   = rcnt_q + 8'd1;
          ren      = 1'b1;
          ren_addr = raddr_d;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read engine state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rfixed_q <= 1'b0;
      rid_q    <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rfixed_q <= rfixed_d;
      rid_q    <= rid_d;
    end
  end

  // RAM read port; output only moves on a fetch, so RDATA holds during stalls.
  always_ff @(posedge CLK) begin
    if (RST)      rdata_q <= '0;
    else if (ren) rdata_q <= mem[ren_addr];
  end

  assign s_axi.S_AXI_AWREADY = (wstate_q == W_IDLE);
  assign s_axi.S_AXI_WREADY  = (wstate_q == W_DATA);
  assign s_axi.S_AXI_BVALID  = (wstate_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_BID     = wid_q;
  assign s_axi.S_AXI_ARREADY = (rstate_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (rstate_q == R_DATA);
  assign s_axi.S_AXI_RLAST   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  // Size fields and undecoded address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWSIZE, s_axi.S_AXI_ARSIZE,
                       s_axi.S_AXI_AWADDR[31:ADDR_WIDTH], s_axi.S_AXI_AWADDR[1:0],
                       s_axi.S_AXI_ARADDR[31:ADDR_WIDTH], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave with a word-array memory model and expectation queues.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_slave_if bus();
  axi_ram_slave #(.ADDR_WIDTH(14)) dut (.CLK(clk), .RST(rst), .s_axi(bus));

  typedef struct packed { logic [31:0] data; logic last; logic id; } rexp_t;
  typedef struct packed { logic [1:0] resp; logic id; } bexp_t;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] ref_mem [4096];
  rexp_t       exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] rx_q[$];
  logic [1:0]  last_bresp = 2'b00;
  logic [31:0] wq_data [256];
  logic [3:0]  wq_strb [256];
  logic        wq_last [256];
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic void timeout(string name);
    checks++;
    $display("FAIL timeout %s: got no handshake, expected one within the cycle budget", name);
  endfunction

  // Memory is 16 KiB; upper bits alias, low two bits select nothing.
  function automatic int widx(logic [31:0] a);
    return int'((a % 32'd16384) >> 2);
  endfunction

  function automatic logic [31:0] beat_addr(logic [31:0] a, logic [1:0] burst, int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  // Compare process: every accepted R/B beat against the model queues; R stability during stalls.
  logic        stall_q = 1'b0;
  logic [31:0] st_data;
  logic        st_last, st_id;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.S_AXI_RVALID && stall_q) begin
        check("R data stable", bus.S_AXI_RDATA, st_data);
        check("R last stable", 32'(bus.S_AXI_RLAST), 32'(st_last));
        check("R id stable", 32'(bus.S_AXI_RID), 32'(st_id));
      end
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (exp_r.size() == 0) begin
          checks++;
          $display("FAIL unexpected R beat: got %h, expected none", bus.S_AXI_RDATA);
        end else begin
          automatic rexp_t e = exp_r.pop_front();
          check("R data", bus.S_AXI_RDATA, e.data);
          check("R last", 32'(bus.S_AXI_RLAST), 32'(e.last));
          check("R id", 32'(bus.S_AXI_RID), 32'(e.id));
          check("R resp", 32'(bus.S_AXI_RRESP), 32'd0);
        end
        rx_q.push_back(bus.S_AXI_RDATA);
      end
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        if (exp_b.size() == 0) begin
          checks++;
          $display("FAIL unexpected B: got resp %h, expected none", bus.S_AXI_BRESP);
        end else begin
          automatic bexp_t b = exp_b.pop_front();
          check("B resp", 32'(bus.S_AXI_BRESP), 32'(b.resp));
          check("B id", 32'(bus.S_AXI_BID), 32'(b.id));
        end
        last_bresp <= bus.S_AXI_BRESP;
      end
    end
    stall_q <= !rst && bus.S_AXI_RVALID && !bus.S_AXI_RREADY;
    st_data <= bus.S_AXI_RDATA;
    st_last <= bus.S_AXI_RLAST;
    st_id   <= bus.S_AXI_RID;
  end

  // Write burst from wq_*; updates the model per accepted beat. Starts/ends at posedge+1.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id);
    logic err;
    int   t;
    int   w;
    err = 1'b0;
    for (int i = 0; i <= len; i++) if (wq_last[i] != (i == len)) err = 1'b1;
    exp_b.push_back('{err ? 2'b10 : 2'b00, id});
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = 8'(len); bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWID = id; bus.S_AXI_AWSIZE = 3'd2; bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_AWREADY && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("AW");
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.S_AXI_WDATA = wq_data[i]; bus.S_AXI_WSTRB = wq_strb[i];
      bus.S_AXI_WLAST = wq_last[i]; bus.S_AXI_WVALID = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.S_AXI_WREADY && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("W");
      w = widx(beat_addr(addr, burst, i));
      for (int b = 0; b < 4; b++) if (wq_strb[i][b]) ref_mem[w][8*b +: 8] = wq_data[i][8*b +: 8];
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    @(negedge clk);
    check("BVALID cycle after last W", 32'(bus.S_AXI_BVALID), 32'd1);
    check("WREADY low after last W", 32'(bus.S_AXI_WREADY), 32'd0);
    t = 0;
    while (!(bus.S_AXI_BVALID && bus.S_AXI_BREADY) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("B");
    @(posedge clk); #1;
  endtask

  // Read burst; bp applies RREADY pattern 1,0,0,1; abort_at>=0 resets after that many beats.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic id, input bit bp, input int abort_at);
    int t;
    int cnt;
    for (int i = 0; i <= len; i++)
      exp_r.push_back('{ref_mem[widx(beat_addr(addr, burst, i))], i == len, id});
    rx_q.delete();
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = 8'(len); bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARID = id; bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_ARREADY && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("AR");
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = pat[0];
    t = 0; cnt = 0;
    while (cnt <= len && t < 2000) begin
      @(negedge clk);
      if (t == 0) check("RVALID low 1 cycle after AR", 32'(bus.S_AXI_RVALID), 32'd0);
      if (t == 1) check("RVALID high 2 cycles after AR", 32'(bus.S_AXI_RVALID), 32'd1);
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) cnt++;
      if (abort_at >= 0 && cnt == abort_at) break;
      @(posedge clk); #1;
      t++;
      bus.S_AXI_RREADY = bp ? pat[t % 4] : 1'b1;
    end
    if (abort_at >= 0 && cnt == abort_at) begin
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.S_AXI_RREADY = 1'b1;
      exp_r.delete();
      @(negedge clk);
      check("RVALID after reset mid-burst", 32'(bus.S_AXI_RVALID), 32'd0);
      check("ARREADY after reset mid-burst", 32'(bus.S_AXI_ARREADY), 32'd1);
      @(posedge clk); #1;
    end else if (cnt <= len) begin
      timeout("R beats");
    end
    bus.S_AXI_RREADY = 1'b1;
  endtask

  task automatic set_beat(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
    wq_data[i] = d; wq_strb[i] = s; wq_last[i] = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected one within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.S_AXI_AWID = 0; bus.S_AXI_AWADDR = 0; bus.S_AXI_AWLEN = 0; bus.S_AXI_AWSIZE = 0;
    bus.S_AXI_AWBURST = 0; bus.S_AXI_AWVALID = 0; bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0;
    bus.S_AXI_WLAST = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 1;
    bus.S_AXI_ARID = 0; bus.S_AXI_ARADDR = 0; bus.S_AXI_ARLEN = 0; bus.S_AXI_ARSIZE = 0;
    bus.S_AXI_ARBURST = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset AWREADY", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("reset ARREADY", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("reset WREADY", 32'(bus.S_AXI_WREADY), 32'd0);
    check("reset BVALID", 32'(bus.S_AXI_BVALID), 32'd0);
    check("reset RVALID", 32'(bus.S_AXI_RVALID), 32'd0);
    check("reset RLAST", 32'(bus.S_AXI_RLAST), 32'd0);
    check("reset BRESP/RRESP", 32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);
    check("reset BID/RID", 32'({bus.S_AXI_BID, bus.S_AXI_RID}), 32'd0);
    check("reset RDATA", bus.S_AXI_RDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write then read
    set_beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
    do_write(32'h10, 0, 2'b01, 1'b1);
    do_read(32'h10, 0, 2'b01, 1'b1, 1'b0, -1);
    check("single read value", rx_q[0], 32'hDEADBEEF);
    do_read(32'h0001_0010, 0, 2'b01, 1'b0, 1'b0, -1);
    check("aliased read value", rx_q[0], 32'hDEADBEEF);

    // Cache-line burst
    for (int i = 0; i < 32; i++) set_beat(i, 32'(i) * 32'h01010101, 4'hF, i == 31);
    do_write(32'h1000, 31, 2'b01, 1'b0);
    do_read(32'h1000, 31, 2'b01, 1'b1, 1'b0, -1);
    check("line beat count", 32'(rx_q.size()), 32'd32);
    check("line beat 5", rx_q[5], 32'h05050505);
    check("line beat 31", rx_q[31], 32'h1F1F1F1F);

    // Strobes
    set_beat(0, 32'hFFFFFFFF, 4'hF, 1'b1);
    do_write(32'h20, 0, 2'b01, 1'b0);
    set_beat(0, 32'h12345678, 4'b0101, 1'b1);
    do_write(32'h20, 0, 2'b01, 1'b0);
    do_read(32'h20, 0, 2'b01, 1'b0, 1'b0, -1);
    check("strobe merge", rx_q[0], 32'hFF34FF78);

    // FIXED burst
    for (int i = 0; i < 4; i++) set_beat(i, 32'(i + 1), 4'hF, i == 3);
    do_write(32'h30, 3, 2'b00, 1'b0);
    do_read(32'h30, 0, 2'b01, 1'b0, 1'b0, -1);
    check("fixed burst final word", rx_q[0], 32'd4);

    // R backpressure
    do_read(32'h1000, 7, 2'b01, 1'b0, 1'b1, -1);
    check("backpressure beat count", 32'(rx_q.size()), 32'd8);
    check("backpressure beat 7", rx_q[7], 32'h07070707);

    // Protocol error: WLAST early on beat 2 of 4
    for (int i = 0; i < 4; i++) set_beat(i, 32'hE0 + 32'(i), 4'hF, i == 2);
    do_write(32'h40, 3, 2'b01, 1'b1);
    check("early WLAST BRESP", 32'(last_bresp), 32'h2);
    do_read(32'h40, 3, 2'b01, 1'b0, 1'b0, -1);
    check("early WLAST beat 3 written", rx_q[3], 32'hE3);

    // Wrap past the top of memory
    set_beat(0, 32'hAAAA0001, 4'hF, 1'b0);
    set_beat(1, 32'hBBBB0002, 4'hF, 1'b1);
    do_write(32'h3FFC, 1, 2'b01, 1'b0);
    check("wrap BRESP", 32'(last_bresp), 32'h0);
    do_read(32'h0, 0, 2'b01, 1'b0, 1'b0, -1);
    check("wrap second beat at 0", rx_q[0], 32'hBBBB0002);
    do_read(32'h3FFC, 0, 2'b01, 1'b0, 1'b0, -1);
    check("wrap first beat at top", rx_q[0], 32'hAAAA0001);

    // Reset at beat 10 of a 32-beat read, then data intact
    do_read(32'h1000, 31, 2'b01, 1'b1, 1'b0, 10);
    do_read(32'h1000, 31, 2'b01, 1'b0, 1'b0, -1);
    check("data intact after reset", rx_q[10], 32'h0A0A0A0A);

    // Overlapping write and read bursts
    for (int i = 0; i < 32; i++) set_beat(i, 32'hC0000000 + 32'(i), 4'hF, i == 31);
    fork
      do_write(32'h2000, 31, 2'b01, 1'b1);
      do_read(32'h1000, 31, 2'b01, 1'b1, 1'b0, -1);
    join
    check("overlap read count", 32'(rx_q.size()), 32'd32);
    do_read(32'h2000, 31, 2'b01, 1'b0, 1'b0, -1);
    check("overlap write last word", rx_q[31], 32'hC000001F);

    repeat (2) @(posedge clk);
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      checks++;
      $display("FAIL leftover expectations: got %0d R / %0d B pending, expected 0", exp_r.size(), exp_b.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI4 responder (slave) backed by a word-addressed block RAM.
- It is the memory-side counterpart of the AXI cache master, used as the main-memory model in simulation and as on-chip RAM in FPGA builds.
- Read and write channels run independently and concurrently: AW/W/B on one RAM port, AR/R on the other.
- Supports single-beat and INCR/FIXED bursts of up to 256 beats, 32-bit data.

Parameters:
ADDR_WIDTH, 14, byte-address bits decoded; memory is 2^ADDR_WIDTH bytes (default 16 KiB, 4096 words); upper address bits are ignored (aliasing).

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
S_AXI_AWID  in  1  write ID
S_AXI_AWADDR  in  32  write burst start byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  ignored; always 4 bytes
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  1  echoed AWID
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARID  in  1  read ID
S_AXI_ARADDR  in  32  read burst start byte address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARSIZE  in  3  ignored
S_AXI_ARBURST  in  2  as AWBURST
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  1  echoed ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 00
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Reset:
  - AWREADY=1, ARREADY=1.
  - WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP = 00; BID, RID = 0; RDATA = 0.
  - Both FSMs go to IDLE. RAM contents are not cleared.
- Reset mid-burst: all valids drop on the next edge and the burst is abandoned. RAM keeps every beat already written.
- Addressing:
  - Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - INCR adds 4 per beat and wraps modulo memory size; FIXED holds the address.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch addr/len/burst/id and clear the beat counter and error flag. Next: W_DATA, AWREADY=0, WREADY=1.
  - W_DATA: on each WVALID&&WREADY, write WDATA to RAM under WSTRB (strobe 0 leaves the byte unchanged), advance addr and count.
    - Error flag sets if WLAST=1 on a beat with count!=len, or WLAST=0 on count==len.
    - The burst always ends after exactly len+1 beats.
    - On the final beat: WREADY=0, BVALID=1, BRESP = error ? 10 : 00, BID = latched id. Next: W_RESP.
  - W_RESP: hold BVALID until BREADY. Then BVALID=0, AWREADY=1, back to W_IDLE.
  - Write throughput is 1 beat/cycle. BVALID rises the cycle after the last W handshake.
- Read FSM (RAM read latency 1 cycle):
  - R_IDLE: ARREADY=1. On AR handshake, latch addr/len/burst/id. Next: R_FETCH, ARREADY=0.
  - R_FETCH: issue RAM read at the current addr. Next: R_DATA.
  - R_DATA: RVALID=1, RDATA = RAM output, RLAST = (count==len).
    - RDATA, RLAST and RID must hold stable while RVALID&&!RREADY.
    - On RVALID&&RREADY with !RLAST: the RAM read of the next address is issued that same cycle, so the next beat is valid on the following cycle.
    - On a handshake with RLAST: RVALID=0, RLAST=0, ARREADY=1, back to R_IDLE.
  - First RVALID is 2 cycles after the AR handshake. Sustained rate is 1 beat/cycle while RREADY=1.
- Concurrency: read and write bursts may overlap, including the same address. A read sampling a word in the same cycle it is written returns the old data; later reads return the new data.
- New AW/AR are not accepted until the previous burst's B/R completes, so at most one outstanding transaction per direction.

Test Plan:
- Single write then read: AW 0x0000_0010 LEN0, WDATA 0xDEADBEEF, WSTRB F, WLAST=1 -> BVALID next cycle, BRESP 00; then AR 0x10 LEN0 -> RVALID 2 cycles after AR handshake, RDATA 0xDEADBEEF, RLAST=1.
- Cache-line burst: AW 0x0000_1000 AWLEN 0x1F INCR with data i*0x01010101 on beat i, BREADY=1 -> exactly 32 W handshakes, one B with OKAY; AR 0x1000 ARLEN 0x1F -> 32 consecutive R beats with RREADY=1, beat i = i*0x01010101, RLAST only on beat 31.
- Strobes and FIXED: write 0xFFFFFFFF to 0x20, then 0x12345678 with WSTRB 0101 -> read gives 0xFF34FF78; FIXED burst LEN3 at 0x30 writing 1,2,3,4 -> word 0x30 reads 4.
- R backpressure: 8-beat read with RREADY toggling 1,0,0,1 -> no beat lost or duplicated, RDATA/RLAST stable while stalled, RLAST on the 8th accepted beat.
- Protocol error and wrap: AWLEN 3 with WLAST on beat 2 -> 4 beats accepted, BRESP 10; INCR burst starting at the last word (0x3FFC) LEN1 -> second beat lands at 0x0000.
- Reset and concurrency: assert RST during a 32-beat read at beat 10 -> RVALID=0 and ARREADY=1 next cycle, earlier written data intact; overlapping 32-beat write and read bursts complete independently with correct B and R.
